// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg : shared load-width encodings and WB result-select enum
// Rev 1.0   : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

endpackage

`default_nettype wire

// File: rtl/load_extend.sv
// ---------------------------------------------------------------------------
// load_extend : byte/halfword/word select and sign/zero extension of loads
// Rev 1.0     : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module load_extend
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr,
  input  logic [XLEN-1:0] word,
  input  logic            mem_read,
  output logic [XLEN-1:0] data,
  output logic            misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_is_half;
  logic        w_is_word;

  assign w_is_half = (funct3 == F3_LH) || (funct3 == F3_LHU);
  assign w_is_word = (funct3 == F3_LW);
  assign misalign  = mem_read & ((w_is_half & addr[0]) | (w_is_word & (addr != 2'b00)));

  always_comb begin
    w_byte = 8'h00;
    case (addr)
      2'd0:    w_byte = word[7:0];
      2'd1:    w_byte = word[15:8];
      2'd2:    w_byte = word[23:16];
      default: w_byte = word[31:24];
    endcase
  end

  assign w_half = addr[1] ? word[31:16] : word[15:0];

  // Misaligned loads yield zero so no partial data ever reaches WB.
  always_comb begin
    data = '0;
    if (mem_read && !misalign) begin
      case (funct3)
        F3_LB:   data = {{(XLEN-8){w_byte[7]}}, w_byte};
        F3_LBU:  data = {{(XLEN-8){1'b0}}, w_byte};
        F3_LH:   data = {{(XLEN-16){w_half[15]}}, w_half};
        F3_LHU:  data = {{(XLEN-16){1'b0}}, w_half};
        F3_LW:   data = word;
        default: data = '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage : MEM/WB pipeline register with load extension, stall, flush
// Rev 1.0      : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mem_wb_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_w,
  input  logic            flush_w,
  input  logic            valid_m,
  input  logic            reg_write_m,
  input  logic [1:0]      result_src_m,
  input  logic            mem_read_m,
  input  logic [2:0]      funct3_m,
  input  logic [XLEN-1:0] alu_result_m,
  input  logic [XLEN-1:0] read_data_m,
  input  logic [XLEN-1:0] pc_plus4_m,
  input  logic [4:0]      rd_m,
  output logic            valid_w,
  output logic            reg_write_w,
  output logic [1:0]      result_src_w,
  output logic [XLEN-1:0] alu_result_w,
  output logic [XLEN-1:0] load_data_w,
  output logic [XLEN-1:0] pc_plus4_w,
  output logic [4:0]      rd_w,
  output logic            misalign_w
);

  logic [XLEN-1:0] w_load_data;
  logic            w_misalign_raw;
  logic            w_misalign;
  logic            w_reg_write;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .funct3   (funct3_m),
    .addr     (alu_result_m[1:0]),
    .word     (read_data_m),
    .mem_read (mem_read_m),
    .data     (w_load_data),
    .misalign (w_misalign_raw)
  );

  assign w_misalign  = w_misalign_raw & valid_m;
  assign w_reg_write = reg_write_m & valid_m & ~w_misalign & (rd_m != 5'd0);

  logic            r_valid;
  logic            r_reg_write;
  logic [1:0]      r_result_src;
  logic [XLEN-1:0] r_alu_result;
  logic [XLEN-1:0] r_load_data;
  logic [XLEN-1:0] r_pc_plus4;
  logic [4:0]      r_rd;
  logic            r_misalign;

  // Flush outranks stall so a squashed instruction never lingers in W.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_w) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_result_src <= 2'b00;
      r_alu_result <= '0;
      r_load_data  <= '0;
      r_pc_plus4   <= '0;
      r_rd         <= 5'd0;
      r_misalign   <= 1'b0;
    end else if (!stall_w) begin
      r_valid      <= valid_m;
      r_reg_write  <= w_reg_write;
      r_result_src <= result_src_m;
      r_alu_result <= alu_result_m;
      r_load_data  <= w_load_data;
      r_pc_plus4   <= pc_plus4_m;
      r_rd         <= rd_m;
      r_misalign   <= w_misalign;
    end
  end

  assign valid_w      = r_valid;
  assign reg_write_w  = r_reg_write;
  assign result_src_w = r_result_src;
  assign alu_result_w = r_alu_result;
  assign load_data_w  = r_load_data;
  assign pc_plus4_w   = r_pc_plus4;
  assign rd_w         = r_rd;
  assign misalign_w   = r_misalign;

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage : directed + randomized checks against a behavioural model
// Rev 1.0         : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall_w, flush_w, valid_m, reg_write_m, mem_read_m;
  logic [1:0]  result_src_m;
  logic [2:0]  funct3_m;
  logic [31:0] alu_result_m, read_data_m, pc_plus4_m;
  logic [4:0]  rd_m;
  logic        valid_w, reg_write_w, misalign_w;
  logic [1:0]  result_src_w;
  logic [31:0] alu_result_w, load_data_w, pc_plus4_w;
  logic [4:0]  rd_w;

  int n_cmp  = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  mem_wb_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall_w(stall_w), .flush_w(flush_w),
    .valid_m(valid_m), .reg_write_m(reg_write_m), .result_src_m(result_src_m),
    .mem_read_m(mem_read_m), .funct3_m(funct3_m), .alu_result_m(alu_result_m),
    .read_data_m(read_data_m), .pc_plus4_m(pc_plus4_m), .rd_m(rd_m),
    .valid_w(valid_w), .reg_write_w(reg_write_w), .result_src_w(result_src_w),
    .alu_result_w(alu_result_w), .load_data_w(load_data_w), .pc_plus4_w(pc_plus4_w),
    .rd_w(rd_w), .misalign_w(misalign_w)
  );

  // Reference load value from the architectural definition of each load.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] w, input logic rd_en);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = w >> (8 * a);
    b  = sh[7:0];
    sh = w >> (16 * a[1]);
    h  = sh[15:0];
    if (!rd_en) return 32'h0;
    if (ref_misalign(f3, a, rd_en)) return 32'h0;
    case (f3)
      3'b000:  return 32'($signed(b));
      3'b100:  return {24'h0, b};
      3'b001:  return 32'($signed(h));
      3'b101:  return {16'h0, h};
      3'b010:  return w;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit ref_misalign(input logic [2:0] f3, input logic [1:0] a, input logic rd_en);
    if (!rd_en) return 1'b0;
    if ((f3 == 3'b001 || f3 == 3'b101) && (a % 2 != 0)) return 1'b1;
    if (f3 == 3'b010 && a != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Expected W-side contents
  logic        e_valid, e_rw, e_mis;
  logic [1:0]  e_src;
  logic [31:0] e_alu, e_ld, e_pc;
  logic [4:0]  e_rd;

  task automatic model_clear();
    e_valid = 0; e_rw = 0; e_mis = 0; e_src = 0;
    e_alu = 0; e_ld = 0; e_pc = 0; e_rd = 0;
  endtask

  always @(posedge clk) begin
    if (!rst_n || flush_w) begin
      model_clear();
    end else if (!stall_w) begin
      e_valid = valid_m;
      e_mis   = valid_m && ref_misalign(funct3_m, alu_result_m[1:0], mem_read_m);
      e_rw    = reg_write_m && valid_m && !e_mis && (rd_m != 0);
      e_src   = result_src_m;
      e_alu   = alu_result_m;
      e_ld    = ref_load(funct3_m, alu_result_m[1:0], read_data_m, mem_read_m);
      e_pc    = pc_plus4_m;
      e_rd    = rd_m;
    end
  end

  // Compare process: DUT vs model on every cycle after the first reset edge.
  always @(negedge clk) begin
    if (check_en) begin
      n_cmp++;
      if ({valid_w, reg_write_w, misalign_w, result_src_w, alu_result_w, load_data_w, pc_plus4_w, rd_w} !==
          {e_valid, e_rw, e_mis, e_src, e_alu, e_ld, e_pc, e_rd}) begin
        n_fail++;
        $display("FAIL model t=%0t act v=%b rw=%b mis=%b src=%b alu=%h ld=%h pc=%h rd=%0d exp v=%b rw=%b mis=%b src=%b alu=%h ld=%h pc=%h rd=%0d",
                 $time, valid_w, reg_write_w, misalign_w, result_src_w, alu_result_w, load_data_w, pc_plus4_w, rd_w,
                 e_valid, e_rw, e_mis, e_src, e_alu, e_ld, e_pc, e_rd);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] src, input logic mr,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rdat,
                       input logic [31:0] pc, input logic [4:0] rd);
    valid_m = v; reg_write_m = rw; result_src_m = src; mem_read_m = mr; funct3_m = f3;
    alu_result_m = alu; read_data_m = rdat; pc_plus4_m = pc; rd_m = rd;
  endtask

  logic [2:0]  lt_f3  [6] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
  logic [1:0]  lt_a   [6] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd0};
  logic [31:0] lt_exp [6] = '{32'h0000007F, 32'hFFFFFFFF, 32'h00000080,
                              32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};

  initial begin
    rst_n = 0; stall_w = 0; flush_w = 0;
    drive(1, 1, 2'b01, 1, 3'b010, 32'h0000_1000, 32'hDEADBEEF, 32'h44, 5'd7);
    model_clear();
    // Reset: two cycles with nonzero inputs
    tick();
    check_en = 1'b1;
    chk("rst_valid", {31'h0, valid_w}, 32'h0);
    chk("rst_ld", load_data_w, 32'h0);
    tick();
    chk("rst_rw", {31'h0, reg_write_w}, 32'h0);
    chk("rst_rd", {27'h0, rd_w}, 32'h0);
    rst_n = 1;
    tick();
    chk("post_rst_valid", {31'h0, valid_w}, 32'h1);
    chk("post_rst_ld", load_data_w, 32'hDEADBEEF);

    // Load extraction
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 2'b01, 1, lt_f3[i], 32'h1000 + 32'(lt_a[i]), 32'h80FF7F01, 32'h8, 5'd3);
      tick();
      chk($sformatf("load%0d", i), load_data_w, lt_exp[i]);
    end

    // Misaligned LW, then aligned LH at same address
    drive(1, 1, 2'b01, 1, 3'b010, 32'h1002, 32'h80FF7F01, 32'h8, 5'd4);
    tick();
    chk("mis_flag", {31'h0, misalign_w}, 32'h1);
    chk("mis_rw", {31'h0, reg_write_w}, 32'h0);
    chk("mis_ld", load_data_w, 32'h0);
    drive(1, 1, 2'b01, 1, 3'b001, 32'h1002, 32'h80FF7F01, 32'h8, 5'd4);
    tick();
    chk("lh_flag", {31'h0, misalign_w}, 32'h0);
    chk("lh_ld", load_data_w, 32'hFFFF80FF);

    // Stall then stall+flush
    drive(1, 1, 2'b00, 0, 3'b000, 32'h12345678, 32'h0, 32'h20, 5'd5);
    tick();
    chk("cap_alu", alu_result_w, 32'h12345678);
    stall_w = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 2'b10, 0, 3'b000, 32'hAAAA0000 + 32'(i), 32'h0, 32'h99, 5'd9);
      tick();
      chk("stall_alu", alu_result_w, 32'h12345678);
      chk("stall_rd", {27'h0, rd_w}, 32'd5);
    end
    flush_w = 1;
    tick();
    chk("flush_valid", {31'h0, valid_w}, 32'h0);
    chk("flush_rw", {31'h0, reg_write_w}, 32'h0);
    chk("flush_alu", alu_result_w, 32'h0);
    stall_w = 0; flush_w = 0;

    // x0 suppression
    drive(1, 1, 2'b10, 0, 3'b000, 32'h0, 32'h0, 32'h104, 5'd0);
    tick();
    chk("x0_rw", {31'h0, reg_write_w}, 32'h0);
    chk("x0_pc", pc_plus4_w, 32'h104);

    // Back-to-back ALU, load, JAL
    drive(1, 1, 2'b00, 0, 3'b000, 32'h55, 32'h0, 32'h10, 5'd1);
    tick();
    chk("b2b0_src", {30'h0, result_src_w}, 32'h0);
    chk("b2b0_alu", alu_result_w, 32'h55);
    drive(1, 1, 2'b01, 1, 3'b010, 32'h200, 32'hCAFEF00D, 32'h14, 5'd2);
    tick();
    chk("b2b1_src", {30'h0, result_src_w}, 32'h1);
    chk("b2b1_ld", load_data_w, 32'hCAFEF00D);
    drive(1, 1, 2'b10, 0, 3'b000, 32'h0, 32'h0, 32'h18, 5'd1);
    tick();
    chk("b2b2_src", {30'h0, result_src_w}, 32'h2);
    chk("b2b2_pc", pc_plus4_w, 32'h18);
    chk("b2b2_valid", {31'h0, valid_w}, 32'h1);

    // Randomized traffic; every cycle checked by the compare process
    for (int i = 0; i < 600; i++) begin
      rst_n   = ($urandom_range(0, 49) != 0);
      stall_w = ($urandom_range(0, 4) == 0);
      flush_w = ($urandom_range(0, 9) == 0);
      drive(($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom_range(0, 2)), 1'($urandom),
            3'($urandom), $urandom, $urandom, $urandom,
            ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom));
      tick();
    end

    rst_n = 1; stall_w = 0; flush_w = 0;
    tick();
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
